// File: rtl/spi_parity_rx_if.sv
// Bus bundle between an SPI parity-link master and its receive endpoint,
// including the local VALID/RD consumer side.
interface spi_parity_rx_if #(
    parameter int unsigned DATA_W = 64
) ();
    logic              SS;
    logic              SCLK;
    logic              SD;
    logic              SACK;
    logic              RD;
    logic [DATA_W-1:0] DATA;
    logic              VALID;
    logic              PAR_ERR;
    logic              FRM_ERR;
    logic              OVERRUN;

    modport master (
        output SS, SCLK, SD, RD,
        input  SACK, DATA, VALID, PAR_ERR, FRM_ERR, OVERRUN
    );

    modport slave (
        input  SS, SCLK, SD, RD,
        output SACK, DATA, VALID, PAR_ERR, FRM_ERR, OVERRUN
    );
endinterface

// File: rtl/spi_parity_rx.sv
// SPI parity-link receive endpoint: deserialises DATA_W bits plus parity per SS frame,
// buffers the word for a VALID/RD consumer and ACKs on SACK. Odd parity: SPI_RX_ODD_PARITY_EN.
module spi_parity_rx #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ACK_CYCLES = 8
) (
    input logic           CLK,
    input logic           RESET,
    spi_parity_rx_if.slave bus
);
    localparam int unsigned FrameBits = DATA_W + 1;
    localparam int unsigned CntW      = $clog2(DATA_W + 3);
    localparam int unsigned AckW      = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
`ifdef SPI_RX_ODD_PARITY_EN
    localparam logic ParSense = 1'b1;
`else
    localparam logic ParSense = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StShift, StCheck, StAck, StWait} state_e;

    state_e            state_q, state_d;
    logic [2:0]        meta_q, meta_d, sync_q, sync_d;  // {ss, sclk, sd}
    logic [1:0]        prev_q, prev_d;                  // {ss, sclk}
    logic [DATA_W:0]   shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AckW-1:0]   ack_cnt_q, ack_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              sack_q, sack_d;
    logic              par_err_q, par_err_d;
    logic              frm_err_q, frm_err_d;
    logic              overrun_q, overrun_d;

    logic ss_sync, sclk_sync, sd_sync, ss_rise, sclk_rise;
    logic len_ok, par_ok, frame_good, can_load, ack_done;

    assign ss_sync    = sync_q[2];
    assign sclk_sync  = sync_q[1];
    assign sd_sync    = sync_q[0];
    assign ss_rise    = ss_sync & ~prev_q[1];
    assign sclk_rise  = sclk_sync & ~prev_q[0];
    assign len_ok     = (cnt_q == CntW'(FrameBits));
    assign par_ok     = ((^shift_q) == ParSense);
    assign frame_good = len_ok & par_ok;
    // RD in the CHECK cycle frees the buffer for the incoming word.
    assign can_load   = ~valid_q | bus.RD;
    assign ack_done   = (ack_cnt_q == AckW'(ACK_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            meta_q    <= 3'b100;
            sync_q    <= 3'b100;
            prev_q    <= 2'b10;
            shift_q   <= '0;
            cnt_q     <= '0;
            ack_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sack_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            ack_cnt_q <= ack_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sack_q    <= sack_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!ss_sync) state_d = StShift;
            StShift: if (ss_rise) state_d = StCheck;
            StCheck: state_d = (frame_good && can_load) ? StAck : StWait;
            StAck:   if (ack_done) state_d = StWait;
            StWait:  if (ss_sync) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        meta_d    = {bus.SS, bus.SCLK, bus.SD};
        sync_d    = meta_q;
        prev_d    = sync_q[2:1];
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        ack_cnt_d = ack_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q & ~bus.RD;
        sack_d    = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        overrun_d = overrun_q;
        unique case (state_q)
            StIdle: begin
                if (!ss_sync) begin
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[DATA_W-1:0], sd_sync};
                    if (cnt_q != CntW'(DATA_W + 2)) cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                if (!len_ok) begin
                    frm_err_d = 1'b1;
                end else if (!par_ok) begin
                    par_err_d = 1'b1;
                end else if (can_load) begin
                    data_d    = shift_q[DATA_W:1];
                    valid_d   = 1'b1;
                    sack_d    = 1'b1;
                    ack_cnt_d = '0;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            StAck: begin
                sack_d = ~ack_done;
                if (!ack_done) ack_cnt_d = ack_cnt_q + 1'b1;
            end
            StWait: ;
            default: ;
        endcase
    end

    assign bus.SACK    = sack_q;
    assign bus.DATA    = data_q;
    assign bus.VALID   = valid_q;
    assign bus.PAR_ERR = par_err_q;
    assign bus.FRM_ERR = frm_err_q;
    assign bus.OVERRUN = overrun_q;
endmodule
